aes128_stream32: RTL and testbench
==================================

# aes128_stream32

32-bit streaming front end for the AES128 encryption core. Accepts key and plaintext as 32-bit words over a valid/ready input stream and assembles them into 128-bit registers. It sequences the core's reset/ce/done protocol and returns the 128-bit ciphertext as four 32-bit words over a valid/ready output stream. Sits between the system bus adapter and the AES128 instance and owns that instance's control pins.

## Interface
- TIMEOUT, 64: maximum cycles in RUN waiting for core_done before aborting.
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_data  in  32  input word.
- in_key  in  1  sampled on word 0 of a group: 1 = key group, 0 = plaintext group.
- out_valid  out  1  ciphertext word valid.
- out_ready  in  1  sink accepts ciphertext word.
- out_data  out  32  ciphertext word.
- busy  out  1  high in CRST, RUN, DRAIN.
- err_timeout  out  1  sticky; set on core timeout.
- core_reset  out  1  core reset (reset OR start pulse).
- core_ce  out  1  core clock enable.
- core_data_in  out  128  plaintext register.
- core_key  out  128  key register.
- core_data_out  in  128  core ciphertext.
- core_done  in  1  core completion flag.

## Operation
- Word order, all streams: word 0 = bits [127:96], word 3 = bits [31:0].
- Input groups of 4 words; a 2-bit word counter advances on each in_valid&in_ready and wraps 3->0. in_key is latched on word 0; in_key on words 1-3 is ignored.
- Key group: words written into the key register at their slots. The key register persists across blocks; reset value 0.
- Plaintext group: words written into the plaintext register. Acceptance of word 3 starts an encryption.
- States:
  - LOAD: in_ready=1. Key group: stay in LOAD. Plaintext word 3 accepted: go to CRST.
  - CRST: one cycle, core_reset=1, core_ce=0. Go to RUN.
  - RUN: core_ce=1, timeout counter increments each cycle.
    - core_done=1: capture core_data_out into the output buffer, go to DRAIN.
    - Otherwise, counter reaches TIMEOUT-1: set err_timeout, go to LOAD, no output produced.
  - DRAIN: core_ce=0, out_valid=1, out_data = buffer word selected by the output counter. The counter advances on out_valid&out_ready; after word 3 is taken, go to LOAD.
- core_data_in and core_key are stable from CRST until RUN is exited; registers update only in LOAD.
- err_timeout is cleared only by reset. Later blocks still run normally with it set.
- Output buffer holds its value after DRAIN; only the next capture overwrites it.

## Timing
- Reset values, held during reset and on the first cycle after it:
  - state=LOAD, counters=0, key/plaintext/output buffers=0.
  - in_ready=0 while reset is high and 1 from the first cycle after it.
  - out_valid=0, busy=0, err_timeout=0, core_ce=0, core_reset=1 while reset is high.
- Plaintext word 3 accepted at edge T: CRST during cycle T+1, RUN (core_ce=1) from cycle T+2.
- core_done sampled high at edge D: core_ce=0 and out_valid=1 from cycle D+1.
  - core_ce is low at least one cycle between blocks.
  - core_done is never observed while out_valid is high.
- Back-to-back: the last output word accepted at edge E gives in_ready=1 in cycle E+1.
- Total latency from last plaintext word to first out_valid = 2 + core latency cycles.
- in_valid is ignored outside LOAD; in_ready=0 there.
- out_data is stable while out_valid=1 and out_ready=0.
- Reset mid-operation (any state) returns to reset values next cycle. Partially loaded groups are discarded and the key register is cleared.

## Test plan
- Key 00010203 04050607 08090a0b 0c0d0e0f, then plaintext 00112233 44556677 8899aabb ccddeeff, out_ready=1 → out words 69c4e0d8 6a7b0430 d8cdb780 70b4c55a; busy low afterward.
- Key 2b7e1516 28aed2a6 abf71588 09cf4f3c, plaintext 3243f6a8 885a308d 313198a2 e0370734, out_ready toggled 1/0 every cycle → 3925841d 02dc09fb dc118597 196a0b32 with out_data stable while stalled.
- Two plaintext groups back-to-back without reloading the key, with in_valid gaps between words → both ciphertexts correct.
  - core_reset pulses exactly once per block.
  - core_ce drops for at least one cycle between blocks.
- Core model that never raises core_done → err_timeout=1 exactly TIMEOUT cycles after entering RUN, out_valid never asserted, in_ready=1 next cycle.
- Reset asserted mid-RUN and mid-DRAIN (after word 1) → all outputs return to reset values next cycle. Fresh key+plaintext afterward yields the correct vector-1 result.
- in_key=1 on word 0 and 0 on words 1-3 → treated as a key group, no encryption started, busy stays 0.

Source files
------------

// File: rtl/aes128_stream32.sv
// 32-bit valid/ready front end for an AES-128 core: assembles key and plaintext words,
// sequences the core's reset/ce/done handshake and streams the ciphertext back out.
`timescale 1ns/1ps

module aes128_stream32 #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         busy,
    output logic         err_timeout,
    output logic         core_reset,
    output logic         core_ce,
    output logic [127:0] core_data_in,
    output logic [127:0] core_key,
    input  logic [127:0] core_data_out,
    input  logic         core_done
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StLoad, StCrst, StRun, StDrain} state_e;

    state_e          state_q;
    logic [1:0]      wcnt_q;
    logic [1:0]      ocnt_q;
    logic [TW-1:0]   tmo_q;
    logic            grp_key_q;
    logic            err_q;
    logic [127:0]    key_q;
    logic [127:0]    pt_q;
    logic [127:0]    obuf_q;
    logic            in_fire;
    logic            is_key;

    assign in_fire = in_valid & in_ready;
    // Group type comes from in_key on word 0 only; later words reuse the latched value.
    assign is_key  = (wcnt_q == 2'd0) ? in_key : grp_key_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StLoad;
            wcnt_q    <= 2'd0;
            ocnt_q    <= 2'd0;
            tmo_q     <= '0;
            grp_key_q <= 1'b0;
            err_q     <= 1'b0;
            key_q     <= '0;
            pt_q      <= '0;
            obuf_q    <= '0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (in_fire) begin
                        wcnt_q <= wcnt_q + 2'd1;
                        if (wcnt_q == 2'd0) grp_key_q <= in_key;
                        // ~wcnt selects word 0 at [127:96] down to word 3 at [31:0].
                        if (is_key) key_q[{~wcnt_q, 5'd0} +: 32] <= in_data;
                        else        pt_q[{~wcnt_q, 5'd0} +: 32]  <= in_data;
                        if (!is_key && wcnt_q == 2'd3) state_q <= StCrst;
                    end
                end
                StCrst: begin
                    tmo_q   <= '0;
                    state_q <= StRun;
                end
                StRun: begin
                    if (core_done) begin
                        obuf_q  <= core_data_out;
                        ocnt_q  <= 2'd0;
                        state_q <= StDrain;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= StLoad;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        ocnt_q <= ocnt_q + 2'd1;
                        if (ocnt_q == 2'd3) state_q <= StLoad;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign in_ready     = ~reset & (state_q == StLoad);
    assign out_valid    = ~reset & (state_q == StDrain);
    assign busy         = ~reset & (state_q != StLoad);
    assign core_ce      = ~reset & (state_q == StRun);
    assign core_reset   = reset | (state_q == StCrst);
    assign err_timeout  = err_q;
    assign out_data     = obuf_q[{~ocnt_q, 5'd0} +: 32];
    assign core_data_in = pt_q;
    assign core_key     = key_q;

endmodule

// File: tb/tb_aes128_stream32.sv
// Bench for aes128_stream32: behavioural AES-128 core model plus scoreboard of expected
// ciphertext words, fed by directed vectors and randomized blocks.
`timescale 1ns/1ps

module tb_aes128_stream32;

    localparam int TIMEOUT = 64;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_key = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_data;
    logic         busy;
    logic         err_timeout;
    logic         core_reset;
    logic         core_ce;
    logic [127:0] core_data_in;
    logic [127:0] core_key;
    logic [127:0] core_data_out = '0;
    logic         core_done = 1'b0;

    aes128_stream32 #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err_timeout(err_timeout),
        .core_reset(core_reset), .core_ce(core_ce),
        .core_data_in(core_data_in), .core_key(core_key),
        .core_data_out(core_data_out), .core_done(core_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc++;

    task automatic chk_word(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- AES-128 reference (FIPS-197) ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++) s[4*c+k] = s[4*c+k] ^ w[c][31 - 8*k -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++) t[rr + 4*c] = s[rr + 4*((c + rr) % 4)];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++) s[4*c+k] = s[4*c+k] ^ w[4*r+c][31 - 8*k -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- core model: done after core_lat enabled cycles ----------------
    int   core_lat = 4;
    int   core_lat_cur = 4;
    int   core_cnt = 0;
    logic never_done = 1'b0;

    always @(posedge clock) begin
        if (core_reset) begin
            core_cnt     <= 0;
            core_done    <= 1'b0;
            core_lat_cur <= core_lat;
        end else if (core_ce && !never_done && !core_done) begin
            if (core_cnt == core_lat_cur - 1) begin
                core_done     <= 1'b1;
                core_data_out <= aes128(core_key, core_data_in);
            end
            core_cnt <= core_cnt + 1;
        end
    end

    // ---------------- out_ready driver: 0 always, 1 toggle, 2 random, 3 manual ----------------
    int or_mode = 0;
    always @(posedge clock) begin
        #1;
        case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // ---------------- scoreboard monitor ----------------
    logic [31:0] exp_q [$];
    logic [31:0] held_data;
    logic [31:0] exp_w;
    logic        held = 1'b0;
    logic        ce_prev = 1'b0;
    int          rst_pulses = 0;
    int          ce_rises = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (core_reset) rst_pulses++;
            if (core_ce && !ce_prev) ce_rises++;
        end
        ce_prev = core_ce;
        if (!reset && out_valid) begin
            if (held) chk_word("stall_stable", 128'(out_data), 128'(held_data));
            if (exp_q.size() == 0) begin
                chk_bit("unexpected_out_valid", out_valid, 1'b0);
            end else if (out_ready) begin
                exp_w = exp_q.pop_front();
                chk_word("out_data", 128'(out_data), 128'(exp_w));
            end
            held      = !out_ready;
            held_data = out_data;
        end else begin
            held = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [127:0] key_model = '0;

    task automatic push_block(input logic [127:0] ct);
        for (int i = 0; i < 4; i++) exp_q.push_back(ct[127 - 32*i -: 32]);
    endtask

    task automatic send_word(input logic [31:0] d, input logic k);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_key = k;
        @(negedge clock);
        while (!in_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk_bit("in_ready_wait", in_ready, 1'b1);
        @(posedge clock); #1;
        in_valid = 1'b0; in_key = 1'b0; in_data = 32'($urandom);
    endtask

    task automatic send_group(input logic [127:0] data, input logic is_key, input int maxgap);
        logic k;
        for (int i = 0; i < 4; i++) begin
            if (i == 0)  k = is_key;
            else if (is_key) k = 1'b0;
            else         k = 1'($urandom_range(0, 1));
            send_word(data[127 - 32*i -: 32], k);
            repeat ($urandom_range(0, maxgap)) begin
                @(posedge clock); #1;
            end
        end
        if (is_key) key_model = data;
    endtask

    task automatic send_key(input logic [127:0] key);
        send_group(key, 1'b1, 0);
        @(negedge clock);
        chk_bit("busy_after_key", busy, 1'b0);
        @(posedge clock); #1;
    endtask

    task automatic send_pt(input logic [127:0] pt, input int maxgap);
        push_block(aes128(key_model, pt));
        send_group(pt, 1'b0, maxgap);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk_bit("idle_reached", n < 3000, 1'b1);
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk_bit("rst_in_ready", in_ready, 1'b0);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_core_ce", core_ce, 1'b0);
        chk_bit("rst_core_reset", core_reset, 1'b1);
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk_bit("post_in_ready", in_ready, 1'b1);
        chk_bit("post_out_valid", out_valid, 1'b0);
        chk_bit("post_busy", busy, 1'b0);
        chk_bit("post_err", err_timeout, 1'b0);
        chk_bit("post_core_ce", core_ce, 1'b0);
        chk_bit("post_core_reset", core_reset, 1'b0);
        chk_word("post_core_key", core_key, '0);
        chk_word("post_core_data_in", core_data_in, '0);
        chk_word("post_out_data", 128'(out_data), '0);
        key_model = '0;
        @(posedge clock); #1;
    endtask

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic run_vector1();
        send_key(K1);
        push_block(C1);
        send_group(P1, 1'b0, 0);
        wait_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int start_c, end_c, n;
        build_sbox();
        do_reset();

        // Known-answer vector 1, sink always ready.
        or_mode = 0; core_lat = 5;
        run_vector1();
        chk_bit("busy_after_v1", busy, 1'b0);

        // Known-answer vector 2 with sink toggling.
        or_mode = 1; core_lat = 7;
        send_key(K2);
        push_block(C2);
        send_group(P2, 1'b0, 0);
        wait_idle();

        // Two plaintext blocks back-to-back under the same key, gaps between words.
        or_mode = 0; core_lat = 3;
        rst_pulses = 0; ce_rises = 0;
        send_pt({$urandom, $urandom, $urandom, $urandom}, 3);
        send_pt({$urandom, $urandom, $urandom, $urandom}, 3);
        wait_idle();
        chk_int("core_reset_pulses", rst_pulses, 2);
        chk_int("core_ce_rises", ce_rises, 2);

        // Core never completes.
        never_done = 1'b1;
        send_group({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);
        start_c = -1; n = 0;
        @(negedge clock);
        while (!err_timeout && n < 300) begin
            if (core_ce && start_c < 0) start_c = cyc;
            @(negedge clock);
            n++;
        end
        end_c = cyc;
        chk_bit("err_timeout_set", err_timeout, 1'b1);
        chk_int("timeout_cycles", end_c - start_c, TIMEOUT);
        chk_bit("timeout_in_ready", in_ready, 1'b1);
        chk_bit("timeout_busy", busy, 1'b0);
        @(posedge clock); #1;
        never_done = 1'b0;

        // Sticky error does not stop later blocks.
        core_lat = 2;
        send_pt({$urandom, $urandom, $urandom, $urandom}, 1);
        wait_idle();
        chk_bit("err_sticky", err_timeout, 1'b1);

        // Reset in the middle of RUN.
        core_lat = 30;
        send_pt({$urandom, $urandom, $urandom, $urandom}, 0);
        repeat (5) begin
            @(posedge clock); #1;
        end
        do_reset();
        core_lat = 4;
        run_vector1();

        // Reset in DRAIN after two words have been taken.
        or_mode = 3; out_ready = 1'b0; core_lat = 3;
        push_block(C1);
        send_group(P1, 1'b0, 0);
        n = 0;
        @(negedge clock);
        while (!out_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk_bit("drain_reached", out_valid, 1'b1);
        @(posedge clock); #1;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 out_ready = 1'b0;
        do_reset();
        or_mode = 0;
        run_vector1();

        // Randomized blocks, random sink backpressure.
        or_mode = 2;
        for (int b = 0; b < 10; b++) begin
            if (b == 0 || $urandom_range(0, 2) == 0)
                send_key({$urandom, $urandom, $urandom, $urandom});
            core_lat = $urandom_range(1, 12);
            send_pt({$urandom, $urandom, $urandom, $urandom}, 2);
        end
        wait_idle();
        chk_bit("final_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
